// File: rtl/ntt_pkg.sv
// ntt_pkg: shared state encoding, default geometry and stage-count helper for the NTT controller.
package ntt_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  localparam int DEF_LOGN = 7;
  localparam int DEF_PIPE_LAT = 2;
  function automatic int num_stages(input int logn);
    return logn / 2 + logn % 2;
  endfunction
endpackage

// File: rtl/ntt_delay_line.sv
// ntt_delay_line: fixed-depth shift register; reset flushes every in-flight entry.
module ntt_delay_line #(
  parameter int W = 1,
  parameter int D = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] sr [D];
  always_ff @(posedge clk)
    if (rst) sr <= '{default: '0};
    else begin
      sr[0] <= d;
      for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
    end
  assign q = sr[D-1];
endmodule

// File: rtl/mr_ntt_ctrl.sv
// mr_ntt_ctrl: mixed radix-4/radix-2 NTT sequencer issuing read, twiddle and write-back addresses.
module mr_ntt_ctrl import ntt_pkg::*; #(
  parameter int LOGN = DEF_LOGN,
  parameter int PIPE_LAT = DEF_PIPE_LAT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            rd_en,
  output logic [LOGN-1:0] rd_addr0,
  output logic [LOGN-1:0] rd_addr1,
  output logic [LOGN-1:0] rd_addr2,
  output logic [LOGN-1:0] rd_addr3,
  output logic [LOGN-1:0] tw_addr,
  output logic            sel,
  output logic            sen,
  output logic            ien,
  output logic            wr_en,
  output logic [LOGN-1:0] wr_addr0,
  output logic [LOGN-1:0] wr_addr1,
  output logic [LOGN-1:0] wr_addr2,
  output logic [LOGN-1:0] wr_addr3
);
  localparam int NST = num_stages(LOGN);
  localparam int R4 = LOGN / 2;
  localparam int JW = LOGN - 2;
  localparam int CW = $clog2(PIPE_LAT + 2);
  localparam int W = 1 + 4 * LOGN;
  state_t state, nxt;
  logic [JW-1:0] j;
  logic [2:0] stage;
  logic [CW-1:0] cnt;
  logic [LOGN-1:0] tw;
  logic run_q, run, r4, last_j, last_d, last_s, act, stage_end;
  logic [3:0] shamt;
  logic [LOGN-1:0] jx, hm, h, base;
  logic [W-1:0] wq;
  always_comb begin
    run = state == S_RUN;
    r4 = stage < 3'(R4);
    last_j = j == '1;
    last_d = cnt == CW'(PIPE_LAT);
    last_s = stage == 3'(NST - 1);
    stage_end = state == S_DRAIN && last_d;
    nxt = state == S_IDLE ? (start ? S_RUN : S_IDLE) :
          state == S_RUN ? (last_j ? S_DRAIN : S_RUN) :
          state == S_DRAIN ? (last_d ? (last_s ? S_DONE : S_RUN) : S_DRAIN) : S_IDLE;
    // h = N >> (2*stage+2); hm masks the in-block offset of group j
    shamt = 4'(LOGN - 2) - {stage, 1'b0};
    jx = {2'b00, j};
    hm = (LOGN'(1) << shamt) - LOGN'(1);
    h = hm + LOGN'(1);
    base = ((jx & ~hm) << 2) | (jx & hm);
    busy = run || state == S_DRAIN;
    done = state == S_DONE;
    rd_en = run;
    rd_addr0 = !run ? '0 : r4 ? base : {j, 2'b00};
    rd_addr1 = !run ? '0 : r4 ? base + (h << 1) : {j, 2'b01};
    rd_addr2 = !run ? '0 : r4 ? base + h : {j, 2'b10};
    rd_addr3 = !run ? '0 : r4 ? base + h + (h << 1) : {j, 2'b11};
    tw_addr = run ? tw : '0;
    // mode window spans one cycle after each read through the last drain cycle
    act = run_q || state == S_DRAIN;
    sel = act && r4;
    ien = act && r4;
    sen = act && !r4;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= S_IDLE;
      j <= '0;
      stage <= '0;
      cnt <= '0;
      tw <= '0;
      run_q <= 1'b0;
    end else begin
      state <= nxt;
      run_q <= run;
      if (run) j <= j + 1'b1;
      cnt <= state == S_DRAIN ? cnt + 1'b1 : '0;
      stage <= state == S_IDLE ? '0 : stage_end ? stage + 1'b1 : stage;
      tw <= state == S_IDLE ? '0 :
            stage_end ? tw + 1'b1 :
            (run && !last_j && (!r4 || ((jx + LOGN'(1)) & hm) == '0)) ? tw + 1'b1 : tw;
    end
  ntt_delay_line #(.W(W), .D(PIPE_LAT + 1)) u_dly (
    .clk(clk),
    .rst(rst),
    .d({rd_en, rd_addr0, rd_addr1, rd_addr2, rd_addr3}),
    .q(wq)
  );
  assign {wr_en, wr_addr0, wr_addr1, wr_addr2, wr_addr3} = wq;
endmodule

// File: tb/tb_mr_ntt_ctrl.sv
// tb_mr_ntt_ctrl: directed vector table plus reset/restart and LOGN=8 sequences.
module tb_mr_ntt_ctrl;
  logic clk = 1'b0;
  logic rst, start, start2;
  logic busy, done, rd_en, sel, sen, ien, wr_en;
  logic [6:0] rd_addr0, rd_addr1, rd_addr2, rd_addr3, tw_addr, wr_addr0, wr_addr1, wr_addr2, wr_addr3;
  logic busy2, done2, rd_en2, sel2, sen2, ien2, wr_en2;
  logic [7:0] r20, r21, r22, r23, tw2, w20, w21, w22, w23;
  always #5 clk = ~clk;

  mr_ntt_ctrl #(.LOGN(7), .PIPE_LAT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .rd_en(rd_en),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_addr3(rd_addr3),
    .tw_addr(tw_addr), .sel(sel), .sen(sen), .ien(ien), .wr_en(wr_en),
    .wr_addr0(wr_addr0), .wr_addr1(wr_addr1), .wr_addr2(wr_addr2), .wr_addr3(wr_addr3)
  );

  mr_ntt_ctrl #(.LOGN(8), .PIPE_LAT(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2), .rd_en(rd_en2),
    .rd_addr0(r20), .rd_addr1(r21), .rd_addr2(r22), .rd_addr3(r23),
    .tw_addr(tw2), .sel(sel2), .sen(sen2), .ien(ien2), .wr_en(wr_en2),
    .wr_addr0(w20), .wr_addr1(w21), .wr_addr2(w22), .wr_addr3(w23)
  );

  typedef struct packed {
    logic [6:0] f;
    logic [6:0] tw, a0, a1, a2, a3, w0, w1, w2, w3;
  } outs_t;
  typedef struct {
    int cyc;
    string nm;
    outs_t exp;
  } vec_t;

  outs_t cur;
  assign cur = {busy, done, rd_en, wr_en, sel, sen, ien, tw_addr,
                rd_addr0, rd_addr1, rd_addr2, rd_addr3, wr_addr0, wr_addr1, wr_addr2, wr_addr3};

  outs_t rec[300];
  vec_t tbl[18];
  int n_tests = 0, n_fail = 0;

  function automatic outs_t mk(input logic [6:0] f, input int tw, a0, a1, a2, a3, w0, w1, w2, w3);
    return {f, 7'(tw), 7'(a0), 7'(a1), 7'(a2), 7'(a3), 7'(w0), 7'(w1), 7'(w2), 7'(w3)};
  endfunction

  task automatic chk(input string nm, input logic [69:0] got, input logic [69:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // flag order: busy done rd_en wr_en sel sen ien
  initial begin
    int n_rd, n_wr, n_both, n_busy, n_done, n_sen2, n_badsel2, n_wr2, last_wr2, done_cyc2;
    tbl[0]  = '{0,   "idle",       mk(7'b0000000, 0,  0,   0,   0,   0,   0,   0,   0,   0)};
    tbl[1]  = '{1,   "s0j0",       mk(7'b1010000, 0,  0,   64,  32,  96,  0,   0,   0,   0)};
    tbl[2]  = '{2,   "s0j1",       mk(7'b1010101, 0,  1,   65,  33,  97,  0,   0,   0,   0)};
    tbl[3]  = '{4,   "s0_wr0",     mk(7'b1011101, 0,  3,   67,  35,  99,  0,   64,  32,  96)};
    tbl[4]  = '{21,  "s0j20",      mk(7'b1011101, 0,  20,  84,  52,  116, 17,  81,  49,  113)};
    tbl[5]  = '{32,  "s0_last",    mk(7'b1011101, 0,  31,  95,  63,  127, 28,  92,  60,  124)};
    tbl[6]  = '{35,  "drain0",     mk(7'b1001101, 0,  0,   0,   0,   0,   31,  95,  63,  127)};
    tbl[7]  = '{36,  "s1j0",       mk(7'b1010000, 1,  0,   16,  8,   24,  0,   0,   0,   0)};
    tbl[8]  = '{44,  "s1j8",       mk(7'b1011101, 2,  32,  48,  40,  56,  5,   21,  13,  29)};
    tbl[9]  = '{67,  "s1_last",    mk(7'b1011101, 4,  103, 119, 111, 127, 100, 116, 108, 124)};
    tbl[10] = '{72,  "s2j1",       mk(7'b1010101, 5,  1,   5,   3,   7,   0,   0,   0,   0)};
    tbl[11] = '{105, "drain2",     mk(7'b1001101, 0,  0,   0,   0,   0,   121, 125, 123, 127)};
    tbl[12] = '{106, "r2j0",       mk(7'b1010000, 21, 0,   1,   2,   3,   0,   0,   0,   0)};
    tbl[13] = '{111, "r2j5",       mk(7'b1011010, 26, 20,  21,  22,  23,  8,   9,   10,  11)};
    tbl[14] = '{137, "r2_last",    mk(7'b1011010, 52, 124, 125, 126, 127, 112, 113, 114, 115)};
    tbl[15] = '{140, "last_wr",    mk(7'b1001010, 0,  0,   0,   0,   0,   124, 125, 126, 127)};
    tbl[16] = '{141, "done",       mk(7'b0100000, 0,  0,   0,   0,   0,   0,   0,   0,   0)};
    tbl[17] = '{142, "idle_after", mk(7'b0000000, 0,  0,   0,   0,   0,   0,   0,   0,   0)};

    rst = 1'b1; start = 1'b0; start2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", cur, '0);
    chk("reset_state2", {busy2, done2, rd_en2, wr_en2, sel2, sen2, ien2, r20, tw2, w20}, '0);
    rst = 1'b0;

    // full LOGN=7 run; start also pulsed while busy (20) and in the done cycle (141)
    for (int c = 0; c < 146; c++) begin
      @(negedge clk);
      rec[c] = cur;
      start = (c == 0 || c == 20 || c == 141);
    end
    for (int i = 0; i < 18; i++) chk(tbl[i].nm, rec[tbl[i].cyc], tbl[i].exp);
    n_rd = 0; n_wr = 0; n_both = 0; n_busy = 0; n_done = 0;
    for (int c = 0; c < 146; c++) begin
      n_rd += int'(rec[c].f[4]);
      n_wr += int'(rec[c].f[3]);
      n_both += int'(rec[c].f[1] & rec[c].f[0]);
      n_busy += int'(rec[c].f[6]);
      n_done += int'(rec[c].f[5]);
    end
    chk("rd_count", 70'(n_rd), 70'(128));
    chk("wr_count", 70'(n_wr), 70'(128));
    chk("sen_ien_both", 70'(n_both), 70'(0));
    chk("busy_count", 70'(n_busy), 70'(140));
    chk("done_count", 70'(n_done), 70'(1));

    // mid-transform reset at cycle 50, restart at 60
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      rec[c] = cur;
      start = (c == 0 || c == 60);
      rst = (c == 50);
    end
    chk("pre_rst", rec[50], mk(7'b1011101, 2, 38, 54, 46, 62, 35, 51, 43, 59));
    chk("rst_51", rec[51], '0);
    chk("rst_52_flush", rec[52], '0);
    chk("rst_53_flush", rec[53], '0);
    chk("restart_61", rec[61], mk(7'b1010000, 0, 0, 64, 32, 96, 0, 0, 0, 0));
    chk("restart_64", rec[64], mk(7'b1011101, 0, 3, 67, 35, 99, 0, 64, 32, 96));
    repeat (150) @(negedge clk);
    chk("idle_after_restart", cur, '0);

    // LOGN=8, PIPE_LAT=1: four radix-4 stages of 64 groups, 2-cycle drains
    n_sen2 = 0; n_badsel2 = 0; n_wr2 = 0; last_wr2 = -1; done_cyc2 = -1;
    for (int c = 0; c < 271; c++) begin
      @(negedge clk);
      if (c == 1) chk("l8_first", {r20, r21, r22, r23, tw2}, {8'd0, 8'd128, 8'd64, 8'd192, 8'd0});
      if (c == 200) chk("l8_s3j1", {r20, r21, r22, r23, tw2}, {8'd4, 8'd6, 8'd5, 8'd7, 8'd22});
      n_sen2 += int'(sen2);
      n_badsel2 += int'(ien2 & ~sel2);
      n_wr2 += int'(wr_en2);
      if (wr_en2) last_wr2 = c;
      if (done2) done_cyc2 = c;
      start2 = (c == 0);
    end
    chk("l8_no_sen", 70'(n_sen2), 70'(0));
    chk("l8_sel_with_ien", 70'(n_badsel2), 70'(0));
    chk("l8_wr_count", 70'(n_wr2), 70'(256));
    chk("l8_last_wr", 70'(last_wr2), 70'(264));
    chk("l8_done", 70'(done_cyc2), 70'(265));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
